// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - state encoding, default timeout and sizing helper for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 15;

  // Wait counter must be able to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_picker.sv
// rtl/arb_picker.sv - combinational two-way picker; prio_i=1 favours m1 on a tie
module arb_picker (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = prio_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master single-port memory arbiter with access timeout
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate winner on ties instead of fixed m0 priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          err
);

  localparam int            CW        = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  arb_state_e    state_q;
  logic          owner_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          mem_req_q;
  logic          m0_ack_q;
  logic          m1_ack_q;
  logic          err_q;
  logic [1:0]    grant;
  logic          prio;

  arb_picker u_picker (
    .req_i   ({m1_req, m0_req}),
    .prio_i  (prio),
    .grant_o (grant)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic prio_q;

  // After each grant, favour the master that did not just win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (state_q == ST_IDLE && grant != 2'b00) begin
      prio_q <= grant[0];
    end
  end

  assign prio = prio_q;
`else
  assign prio = 1'b0;
`endif

  assign cnt_d = cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            owner_q   <= grant[1];
            we_q      <= grant[1] ? m1_we    : m0_we;
            addr_q    <= grant[1] ? m1_addr  : m0_addr;
            wdata_q   <= grant[1] ? m1_wdata : m0_wdata;
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            state_q   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            rdata_q   <= we_q ? '0 : mem_rdata;
            mem_req_q <= 1'b0;
            m0_ack_q  <= ~owner_q;
            m1_ack_q  <= owner_q;
            state_q   <= ST_ACK;
          end else if (cnt_d == CNT_LIMIT) begin
            rdata_q   <= '0;
            err_q     <= 1'b1;
            mem_req_q <= 1'b0;
            m0_ack_q  <= ~owner_q;
            m1_ack_q  <= owner_q;
            state_q   <= ST_ACK;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_ack_q ? rdata_q : '0;
  assign m1_rdata  = m1_ack_q ? rdata_q : '0;
  assign err       = err_q;

endmodule
